// File: rtl/multdiv_pkg.sv
// Shared types and constants for the sequential signed multiply/divide unit.
package multdiv_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned ITER  = 32;
  localparam int unsigned CNT_W = $clog2(ITER) + 1;
  localparam int unsigned GRP_W = 4;
  localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/cla32.sv
// 32-bit carry-lookahead adder: 4-bit groups with group generate/propagate
// feeding the inter-group carry chain.
module cla32
  import multdiv_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned GROUPS = WIDTH / GRP_W;

  always_comb begin
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;
    logic             gg;
    logic             gp;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int k = 0; k < GROUPS; k++) begin
      gg = 1'b0;
      gp = 1'b1;
      for (int i = 0; i < GRP_W; i++) begin
        gg = g[k*GRP_W+i] | (p[k*GRP_W+i] & gg);
        gp = gp & p[k*GRP_W+i];
      end
      for (int i = 0; i < GRP_W - 1; i++) begin
        c[k*GRP_W+i+1] = g[k*GRP_W+i] | (p[k*GRP_W+i] & c[k*GRP_W+i]);
      end
      // group carry-out skips the in-group ripple
      c[(k+1)*GRP_W] = gg | (gp & c[k*GRP_W]);
    end
    sum  = p ^ c[WIDTH-1:0];
    cout = c[WIDTH];
  end

endmodule

// File: rtl/multdiv_seq.sv
// Sequential signed 32x32 multiply (radix-2 Booth) and divide (restoring on
// magnitudes), both iterating over a single shared CLA; fixed 33-cycle latency.
module multdiv_seq #(
  parameter int unsigned WIDTH = multdiv_pkg::WIDTH,
  parameter int unsigned ITER  = multdiv_pkg::ITER
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  import multdiv_pkg::*;

  state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             qm1_q, qm1_d;
  logic             neg_q, neg_d;
  logic             bz_q, bz_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;

  logic             start_mul_c, start_div_c, start_c, iter_c;
  logic [WIDTH-1:0] add_a_c, add_b_c, add_s_c;
  logic             add_cin_c, add_cout_c;
  logic             mul_sign_c, mul_ovf_c;
  logic [WIDTH:0]   prod_hi_c;

  assign start_mul_c = ctrl_MULT & ~ctrl_DIV;
  assign start_div_c = ctrl_DIV & ~ctrl_MULT;
  assign start_c     = start_mul_c | start_div_c;
  assign iter_c      = (cnt_q < CNT_W'(ITER));

  // true sign of the 33-bit Booth partial sum, so M = INT_MIN cannot overflow
  assign mul_sign_c = add_a_c[WIDTH-1] ^ add_b_c[WIDTH-1] ^ add_cout_c;
  assign prod_hi_c  = {acc_q, q_q[WIDTH-1]};
  assign mul_ovf_c  = ~((&prod_hi_c) | ~(|prod_hi_c));

  cla32 u_cla (
    .a   (add_a_c),
    .b   (add_b_c),
    .cin (add_cin_c),
    .sum (add_s_c),
    .cout(add_cout_c)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start_mul_c) begin
      state_d = MUL;
    end else if (start_div_c) begin
      state_d = DIV;
    end else begin
      case (state_q)
        MUL, DIV: if (!iter_c) state_d = DONE;
        DONE:     state_d = IDLE;
        default:  state_d = state_q;
      endcase
    end
  end

  // Adder operand mux: |A| on start, Booth/restoring step, quotient negate.
  always_comb begin
    add_a_c   = '0;
    add_b_c   = '0;
    add_cin_c = 1'b0;
    if (start_c) begin
      add_b_c   = ~data_operandA;
      add_cin_c = 1'b1;
    end else if (state_q == MUL && iter_c) begin
      add_a_c = acc_q;
      case ({q_q[0], qm1_q})
        2'b01: add_b_c = m_q;
        2'b10: begin
          add_b_c   = ~m_q;
          add_cin_c = 1'b1;
        end
        default: add_b_c = '0;
      endcase
    end else if (state_q == DIV && iter_c) begin
      // R - |B|: add B directly when negative, else add ~B + 1
      add_a_c   = {acc_q[WIDTH-2:0], q_q[WIDTH-1]};
      add_b_c   = m_q[WIDTH-1] ? m_q : ~m_q;
      add_cin_c = ~m_q[WIDTH-1];
    end else if (state_q == DIV) begin
      add_b_c   = ~q_q;
      add_cin_c = 1'b1;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    q_d    = q_q;
    m_d    = m_q;
    qm1_d  = qm1_q;
    neg_d  = neg_q;
    bz_d   = bz_q;
    res_d  = res_q;
    exc_d  = exc_q;
    rdy_d  = (state_d == DONE);
    busy_d = (state_d == MUL) || (state_d == DIV);
    if (start_c) begin
      cnt_d = '0;
      acc_d = '0;
      qm1_d = 1'b0;
      if (start_mul_c) begin
        m_d   = data_operandA;
        q_d   = data_operandB;
        neg_d = 1'b0;
        bz_d  = 1'b0;
      end else begin
        m_d   = data_operandB;
        q_d   = data_operandA[WIDTH-1] ? add_s_c : data_operandA;
        neg_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        bz_d  = (data_operandB == '0);
      end
    end else if (state_q == MUL) begin
      if (iter_c) begin
        acc_d = {mul_sign_c, add_s_c[WIDTH-1:1]};
        q_d   = {add_s_c[0], q_q[WIDTH-1:1]};
        qm1_d = q_q[0];
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        res_d = q_q;
        exc_d = mul_ovf_c;
      end
    end else if (state_q == DIV) begin
      if (iter_c) begin
        acc_d = add_cout_c ? add_s_c : add_a_c;
        q_d   = {q_q[WIDTH-2:0], add_cout_c};
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        // only INT_MIN / -1 yields a positive quotient with the top bit set
        res_d = bz_q ? '0 : (neg_q ? add_s_c : q_q);
        exc_d = bz_q | (~neg_q & q_q[WIDTH-1]);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      q_q    <= '0;
      m_q    <= '0;
      qm1_q  <= 1'b0;
      neg_q  <= 1'b0;
      bz_q   <= 1'b0;
      res_q  <= '0;
      exc_q  <= 1'b0;
      rdy_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      q_q    <= q_d;
      m_q    <= m_d;
      qm1_q  <= qm1_d;
      neg_q  <= neg_d;
      bz_q   <= bz_d;
      res_q  <= res_d;
      exc_q  <= exc_d;
      rdy_q  <= rdy_d;
      busy_q <= busy_d;
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_seq.sv
// Directed-vector bench for multdiv_seq: table of signed mul/div cases plus
// abort, simultaneous-start, async-reset and back-to-back sequences.
module tb_multdiv_seq;
  import multdiv_pkg::*;

  typedef struct {
    logic        mul;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  localparam int unsigned NVEC = 15;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs [NVEC];

  multdiv_seq dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, required %08h", name, act, exp);
    end
  endtask

  // Start edge is the posedge inside this task; returns #1 after it.
  task automatic start_op(input logic mul, input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT     = mul;
    ctrl_DIV      = ~mul;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_rdy(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = busy ? 1 : 0;
    for (int e = 1; e <= 40 && lat == 0; e++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) lat = e;
      else if (busy) busy_cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int bc;
    int cnt;

    vecs[0]  = '{1'b1, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
    vecs[2]  = '{1'b1, INT_MIN,       32'd1,         INT_MIN,       1'b0};
    vecs[3]  = '{1'b1, INT_MIN,       INT_MIN,       32'h0000_0000, 1'b1};
    vecs[4]  = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         1'b0};
    vecs[5]  = '{1'b1, 32'h7FFF_FFFF, 32'd2,         32'hFFFF_FFFE, 1'b1};
    vecs[6]  = '{1'b0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0};
    vecs[7]  = '{1'b0, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0};
    vecs[8]  = '{1'b0, 32'd5,         32'd0,         32'd0,         1'b1};
    vecs[9]  = '{1'b0, INT_MIN,       32'hFFFF_FFFF, INT_MIN,       1'b1};
    vecs[10] = '{1'b0, INT_MIN,       32'd1,         INT_MIN,       1'b0};
    vecs[11] = '{1'b0, 32'd7,         32'd7,         32'd1,         1'b0};
    vecs[12] = '{1'b0, 32'd3,         32'd7,         32'd0,         1'b0};
    vecs[13] = '{1'b0, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        1'b0};
    vecs[14] = '{1'b0, 32'h7FFF_FFFF, INT_MIN,       32'd0,         1'b0};

    reset_n       = 1'b0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    #12;
    check("reset_result", data_result, 32'd0);
    check("reset_exception", 32'(data_exception), 32'd0);
    check("reset_rdy", 32'(data_resultRDY), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    for (int i = 0; i < NVEC; i++) begin
      start_op(vecs[i].mul, vecs[i].a, vecs[i].b);
      wait_rdy(lat, bc);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd33);
      check($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'd33);
      check($sformatf("v%0d_busy_at_rdy", i), 32'(busy), 32'd0);
      check($sformatf("v%0d_result", i), data_result, vecs[i].res);
      check($sformatf("v%0d_exception", i), 32'(data_exception), 32'(vecs[i].exc));
      @(posedge clock);
      #1;
      check($sformatf("v%0d_rdy_drop", i), 32'(data_resultRDY), 32'd0);
      check($sformatf("v%0d_result_hold", i), data_result, vecs[i].res);
    end

    // MUL 3x4 aborted by DIV 9/3 on edge 10
    start_op(1'b1, 32'd3, 32'd4);
    cnt = 0;
    repeat (9) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) cnt++;
    end
    start_op(1'b0, 32'd9, 32'd3);
    wait_rdy(lat, bc);
    check("abort_latency", 32'(lat), 32'd33);
    check("abort_result", data_result, 32'd3);
    check("abort_exception", 32'(data_exception), 32'd0);
    repeat (40) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) cnt++;
    end
    check("abort_single_rdy", 32'(cnt), 32'd0);

    // both start pulses together are ignored
    ctrl_MULT     = 1'b1;
    ctrl_DIV      = 1'b1;
    data_operandA = 32'd11;
    data_operandB = 32'd13;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    check("both_busy", 32'(busy), 32'd0);
    cnt = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (data_resultRDY || busy) cnt++;
    end
    check("both_no_activity", 32'(cnt), 32'd0);
    check("both_result_hold", data_result, 32'd3);

    // async reset in the middle of a multiply
    start_op(1'b1, 32'd5, 32'd5);
    repeat (15) @(posedge clock);
    #1;
    check("midrst_busy_before", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_result", data_result, 32'd0);
    check("midrst_exception", 32'(data_exception), 32'd0);
    check("midrst_rdy", 32'(data_resultRDY), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("postrst_busy", 32'(busy), 32'd0);
    start_op(1'b1, 32'd6, 32'd7);
    wait_rdy(lat, bc);
    check("postrst_latency", 32'(lat), 32'd33);
    check("postrst_result", data_result, 32'd42);

    // new start issued on the RDY cycle
    @(posedge clock);
    #1;
    start_op(1'b1, 32'd2, 32'd3);
    wait_rdy(lat, bc);
    check("chain_first_latency", 32'(lat), 32'd33);
    check("chain_first_result", data_result, 32'd6);
    start_op(1'b0, 32'd100, 32'hFFFF_FFF9);
    check("chain_rdy_drop", 32'(data_resultRDY), 32'd0);
    check("chain_busy", 32'(busy), 32'd1);
    check("chain_hold", data_result, 32'd6);
    wait_rdy(lat, bc);
    check("chain_second_latency", 32'(lat), 32'd33);
    check("chain_second_result", data_result, 32'hFFFF_FFF2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
